// File: rtl/dec_nto2n_seq.sv
// Registered SEL_W-to-2^SEL_W decoder with a valid/ready input handshake,
// one-hot / thermometer decode and a self-timed scan that walks the lit bit around the ring.
module dec_nto2n_seq #(
    parameter int SEL_W    = 3,
    parameter int SCAN_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  sel_valid,
    output logic                  sel_ready,
    output logic [2**SEL_W-1:0]   dout,
    output logic                  dout_valid,
    output logic [SEL_W-1:0]      scan_idx,
    output logic                  scan_wrap
);

    localparam int OUT_N = 2**SEL_W;
    localparam int DIV_W = $clog2(SCAN_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [OUT_N-1:0] ONE      = OUT_N'(1);
    localparam logic [OUT_N-1:0] ALL_ONES = {OUT_N{1'b1}};
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(OUT_N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_SCAN
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [OUT_N-1:0]   dout_d;
    logic               dout_valid_d;
    logic [SEL_W-1:0]   scan_idx_d;
    logic               scan_wrap_d;
    logic               accept;
    logic [SEL_W-1:0]   idx_next;
    logic [OUT_N-1:0]   onehot_sel;
    logic [OUT_N-1:0]   therm_sel;

    assign sel_ready  = en & (state_q != S_SCAN) & ~rst;
    assign accept     = sel_valid & sel_ready;
    assign idx_next   = scan_idx + SEL_W'(1);
    assign onehot_sel = ONE << sel;
    // ~sel equals OUT_N-1-sel, so this keeps bits [sel:0] set: same as ((2<<sel)-1).
    assign therm_sel  = ALL_ONES >> (~sel);

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        dout_d       = dout;
        dout_valid_d = 1'b0;
        scan_idx_d   = scan_idx;
        scan_wrap_d  = 1'b0;
        case (state_q)
            S_IDLE, S_HOLD: begin
                if (accept) begin
                    dout_valid_d = 1'b1;
                    scan_idx_d   = sel;
                    case (mode)
                        2'b01: begin
                            dout_d  = therm_sel;
                            state_d = S_HOLD;
                        end
                        2'b10: begin
                            dout_d  = onehot_sel;
                            div_d   = '0;
                            state_d = S_SCAN;
                        end
                        default: begin
                            dout_d  = onehot_sel;
                            state_d = S_HOLD;
                        end
                    endcase
                end else if (!en) begin
                    dout_d  = '0;
                    state_d = S_IDLE;
                end
            end
            S_SCAN: begin
                if (!en || mode != 2'b10) begin
                    dout_d  = '0;
                    div_d   = '0;
                    state_d = S_IDLE;
                end else if (div_q == DIV_LAST) begin
                    div_d       = '0;
                    scan_idx_d  = idx_next;
                    dout_d      = ONE << idx_next;
                    scan_wrap_d = (scan_idx == IDX_LAST);
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                dout_d  = '0;
                div_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            scan_idx   <= '0;
            scan_wrap  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            dout       <= dout_d;
            dout_valid <= dout_valid_d;
            scan_idx   <= scan_idx_d;
            scan_wrap  <= scan_wrap_d;
        end
    end

endmodule
